decoder_sigmoid_seq: RTL and testbench
======================================

Name: decoder_sigmoid_seq

Overview:
- Output activation stage placed directly downstream of the decoder affine layer (z·W + b).
- Accepts one full M_output-element vector of 32-bit fixed-point pre-activations and applies a PLAN piecewise-linear sigmoid one element per cycle, using only shifts and adds.
- Holds the reconstructed vector behind a valid/ready handshake until it is consumed.
- Time-multiplexing one PLAN datapath keeps area small compared with M_output parallel activation units.

Parameters:
- N_ELEM, 9, number of vector elements (equals decoder M_output).
- BITSIZE, 32, word width; two's complement.
- FRAC_BITS, 16, fractional bits (Q15.16). All constants below are quoted for FRAC_BITS=16.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a vector.
- in_data  in  N_ELEM*BITSIZE  pre-activation vector; element k is in_data[(k+1)*BITSIZE-1:k*BITSIZE].
- out_valid  out  1  out_data holds a complete result.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  N_ELEM*BITSIZE  sigmoid vector; same packing as in_data.
- busy  out  1  high in COMPUTE or DONE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- Reset state: while rst_n=0 at a clk edge, the block goes to IDLE, and idx=0, out_valid=0, out_data=0, the input capture register=0, and busy=0. Any in-progress vector is discarded. in_valid and out_ready are ignored on reset edges.
- FSM states: IDLE, COMPUTE, DONE.
- in_ready is 1 only in IDLE. out_valid is 1 only in DONE. Both are decoded from the state register.
- IDLE:
  - When in_valid & in_ready at an edge, capture in_data, set idx=0, and go to COMPUTE.
- COMPUTE:
  - Each cycle, element idx of the capture register passes through PLAN, and the result is written to out_data slot idx.
  - idx increments each cycle. When idx==N_ELEM-1 is written, go to DONE.
  - Inputs are not sampled in this state.
- DONE:
  - out_data is stable.
  - When out_ready is high at an edge, go to IDLE. out_data keeps its value after the handshake.
  - in_valid is not accepted in the same cycle as out_ready, because in_ready=0. It can be accepted in the following IDLE cycle.
- Latency: if acceptance occurs at edge E, out_valid is high after edge E+N_ELEM (9 cycles). Minimum throughput is one vector per N_ELEM+2 cycles.
- Backpressure: DONE is held indefinitely. out_data must not change while out_valid=1.
- PLAN function, with a=|x|:
  - Computing a: if x is the most negative value (0x80000000), a saturates to 0x7FFFFFFF.
  - a >= 5.0 (327680): y = 1.0 (65536).
  - 2.375 (155648) <= a < 5.0: y = (a>>5) + 0.84375 (55296).
  - 1.0 (65536) <= a < 2.375: y = (a>>3) + 0.625 (40960).
  - a < 1.0: y = (a>>2) + 0.5 (32768).
  - Shifts are logical on the non-negative a and truncate.
  - If x < 0, the output is 65536 - y. Otherwise the output is y.
  - The result is always in [0, 65536], with upper bits zero.
- The PLAN datapath is combinational between the capture register and the out_data register. There are no extra pipeline stages.

Test Plan:
- Reset, then a vector of elements {0, 1.0, -1.0, 0.5, 3.0, 6.0, -6.0, 0x80000000, 2.375} (raw values 0, 65536, -65536, 32768, 196608, 393216, -393216, 0x80000000, 155648), with out_ready=1. Required: out_data = {32768, 49152, 16384, 40960, 61440, 65536, 0, 0, 60160}, and out_valid rises 9 cycles after acceptance.
- Segment edges: inputs 155647, 65535, 327679, 327680. Required outputs: 60415, 49151, 65535, 65536.
- Backpressure: hold out_ready=0 for 20 cycles after DONE. Required: out_valid stays 1, out_data is constant, and in_ready=0 while in_valid=1 is driven. Then pulse out_ready: in_ready=1 on the next cycle, and a new vector is accepted.
- Reset mid-operation: assert rst_n=0 for one edge at idx=4 of COMPUTE. Required: next state IDLE, out_valid=0, out_data=0, busy=0. A following vector completes correctly.
- Back-to-back: two vectors with in_valid held high and out_ready held high. Required: second acceptance exactly N_ELEM+2 cycles after the first, and both results are correct.
- No spurious accept: pulse in_valid during COMPUTE. Required: the capture register is unchanged and the result matches the original vector.

Source files
------------

// File: rtl/decoder_sigmoid_seq.sv
// Piecewise-linear (PLAN) sigmoid over an N_ELEM vector, one element per cycle; out_valid N_ELEM cycles after accept.
// Result is held in DONE until out_ready; in_ready is high only in IDLE, so no new vector enters while one is pending.
module decoder_sigmoid_seq #(
  parameter int N_ELEM    = 9,
  parameter int BITSIZE   = 32,
  parameter int FRAC_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [N_ELEM*BITSIZE-1:0]   in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [N_ELEM*BITSIZE-1:0]   out_data,
  output logic                        busy
);

  localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

  // Segment breakpoints and offsets, derived from FRAC_BITS
  localparam logic [BITSIZE-1:0] ONE    = BITSIZE'(64'd1  << FRAC_BITS);
  localparam logic [BITSIZE-1:0] HALF   = BITSIZE'(64'd1  << (FRAC_BITS - 1));
  localparam logic [BITSIZE-1:0] FIVE   = BITSIZE'(64'd5  << FRAC_BITS);
  localparam logic [BITSIZE-1:0] T2375  = BITSIZE'(64'd19 << (FRAC_BITS - 3));
  localparam logic [BITSIZE-1:0] C0625  = BITSIZE'(64'd5  << (FRAC_BITS - 3));
  localparam logic [BITSIZE-1:0] C84375 = BITSIZE'(64'd27 << (FRAC_BITS - 5));
  localparam logic [BITSIZE-1:0] MOST_NEG = {1'b1, {(BITSIZE-1){1'b0}}};
  localparam logic [BITSIZE-1:0] MOST_POS = {1'b0, {(BITSIZE-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic [N_ELEM-1:0][BITSIZE-1:0] cap_q;
  logic [N_ELEM-1:0][BITSIZE-1:0] res_q;

  function automatic logic [BITSIZE-1:0] plan(input logic [BITSIZE-1:0] x);
    logic [BITSIZE-1:0] a;
    logic [BITSIZE-1:0] y;
    a = x;
    y = '0;
    // |MOST_NEG| does not fit, so it saturates to the largest positive value
    if (x == MOST_NEG) begin
      a = MOST_POS;
    end else if (x[BITSIZE-1]) begin
      a = -x;
    end
    if (a >= FIVE) begin
      y = ONE;
    end else if (a >= T2375) begin
      y = (a >> 5) + C84375;
    end else if (a >= ONE) begin
      y = (a >> 3) + C0625;
    end else begin
      y = (a >> 2) + HALF;
    end
    plan = x[BITSIZE-1] ? (ONE - y) : y;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = COMPUTE;
        end
      end
      COMPUTE: begin
        busy = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      cap_q <= '0;
      res_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            cap_q <= in_data;
            idx_q <= '0;
          end
        end
        COMPUTE: begin
          res_q[idx_q] <= plan(cap_q[idx_q]);
          idx_q        <= (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign out_data = res_q;

endmodule

// File: tb/tb_decoder_sigmoid_seq.sv
// Directed bench for decoder_sigmoid_seq: hand-computed PLAN results, latency, backpressure, reset and handshake checks.
module tb_decoder_sigmoid_seq;

  localparam int N  = 9;
  localparam int B  = 32;
  localparam int VW = N * B;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [VW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [VW-1:0] out_data;
  logic          busy;

  int n_cmp = 0;
  int n_err = 0;

  decoder_sigmoid_seq #(.N_ELEM(N), .BITSIZE(B), .FRAC_BITS(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [VW-1:0] pack(input logic [B-1:0] v [N]);
    logic [VW-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*B +: B] = v[k];
    return r;
  endfunction

  // Present a vector and return once the accepting edge has passed
  task automatic push(input logic [VW-1:0] v, input string tag);
    int t;
    t = 0;
    in_data  = v;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      tick();
      t++;
    end
    check({tag, "_accept_timeout"}, VW'(in_ready), VW'(1));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  logic [B-1:0] v1 [N] = '{32'd0, 32'd65536, -32'sd65536, 32'd32768, 32'd196608,
                           32'd393216, -32'sd393216, 32'h80000000, 32'd155648};
  logic [B-1:0] e1 [N] = '{32'd32768, 32'd49152, 32'd16384, 32'd40960, 32'd61440,
                           32'd65536, 32'd0, 32'd0, 32'd60160};
  logic [B-1:0] v2 [N] = '{32'd155647, 32'd65535, 32'd327679, 32'd327680, -32'sd65535,
                           32'd327681, -32'sd327679, 32'd1, -32'sd1};
  logic [B-1:0] e2 [N] = '{32'd60415, 32'd49151, 32'd65535, 32'd65536, 32'd16385,
                           32'd65536, 32'd1, 32'd32768, 32'd32768};

  initial begin
    int lat;
    int n_acc;
    int n_done;
    int acc_t [2];
    logic [VW-1:0] pv1, pe1, pv2, pe2;
    pv1 = pack(v1); pe1 = pack(e1);
    pv2 = pack(v2); pe2 = pack(e2);

    // Reset state
    repeat (3) tick();
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_busy", VW'(busy), VW'(0));
    check("rst_out_data", out_data, '0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", VW'(in_ready), VW'(1));

    // Main vector with latency
    out_ready = 1'b1;
    push(pv1, "v1");
    check("v1_busy", VW'(busy), VW'(1));
    wait_done(lat);
    check("v1_latency", VW'(lat), VW'(N));
    for (int k = 0; k < N; k++)
      check($sformatf("v1_elem%0d", k), VW'(out_data[k*B +: B]), VW'(e1[k]));
    tick();
    check("v1_hold_after_hs", out_data, pe1);
    check("v1_back_idle", VW'(in_ready), VW'(1));

    // Segment edges
    push(pv2, "v2");
    wait_done(lat);
    check("v2_latency", VW'(lat), VW'(N));
    for (int k = 0; k < N; k++)
      check($sformatf("v2_elem%0d", k), VW'(out_data[k*B +: B]), VW'(e2[k]));
    tick();

    // Backpressure
    out_ready = 1'b0;
    push(pv1, "bp");
    wait_done(lat);
    check("bp_latency", VW'(lat), VW'(N));
    in_data  = pv2;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_out_valid", VW'(out_valid), VW'(1));
      check("bp_in_ready", VW'(in_ready), VW'(0));
      check("bp_out_data", out_data, pe1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_in_ready", VW'(in_ready), VW'(1));
    tick();
    in_valid = 1'b0;
    check("bp_new_accept_busy", VW'(busy), VW'(1));
    wait_done(lat);
    check("bp_new_latency", VW'(lat), VW'(N));
    check("bp_new_data", out_data, pe2);
    out_ready = 1'b1;
    tick();

    // Reset in the middle of COMPUTE (idx=4)
    push(pv1, "mid");
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_out_valid", VW'(out_valid), VW'(0));
    check("mid_out_data", out_data, '0);
    check("mid_busy", VW'(busy), VW'(0));
    check("mid_in_ready", VW'(in_ready), VW'(1));
    push(pv2, "mid2");
    wait_done(lat);
    check("mid2_latency", VW'(lat), VW'(N));
    check("mid2_data", out_data, pe2);
    tick();

    // Back-to-back with in_valid and out_ready held high
    n_acc = 0; n_done = 0; acc_t[0] = 0; acc_t[1] = 0;
    in_data  = pv1;
    in_valid = 1'b1;
    for (int i = 0; i < 60 && n_done < 2; i++) begin
      if (in_ready && in_valid && n_acc < 2) begin
        acc_t[n_acc] = i;
        n_acc++;
      end
      tick();
      if (n_acc == 1) in_data = pv2;
      if (n_acc == 2) in_valid = 1'b0;
      if (out_valid) begin
        check($sformatf("b2b_data%0d", n_done), out_data, (n_done == 0) ? pe1 : pe2);
        n_done++;
      end
    end
    in_valid = 1'b0;
    check("b2b_done_count", VW'(n_done), VW'(2));
    check("b2b_spacing", VW'(acc_t[1] - acc_t[0]), VW'(N + 2));
    tick();

    // in_valid pulsed during COMPUTE must be ignored
    push(pv2, "ns");
    repeat (2) tick();
    in_data  = pv1;
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    wait_done(lat);
    check("ns_latency", VW'(lat + 5), VW'(N));
    check("ns_data", out_data, pe2);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
